// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - forwarding-select encodings and busy-FSM state type
package hazard_pkg;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  typedef enum logic {
    RUN     = 1'b0,
    MD_BUSY = 1'b1
  } hz_state_e;

endpackage

// File: rtl/muldiv_busy_ctr.sv
// rtl/muldiv_busy_ctr.sv - mul/div occupancy counter with load, decrement and last flag
module muldiv_busy_ctr #(
  parameter int LATENCY = 32,
  parameter int CW      = (LATENCY > 2) ? $clog2(LATENCY) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_load,
  input  logic          i_dec,
  output logic          o_last,
  output logic [CW-1:0] o_cnt
);

  localparam logic [CW-1:0] LOAD_VAL = CW'(LATENCY - 1);

  logic [CW-1:0] r_cnt;

  // The final decrement (1 -> 0) coincides with the FSM returning to RUN.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= LOAD_VAL;
    end else if (i_dec && (r_cnt != '0)) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_last = (r_cnt == CW'(1));
  assign o_cnt  = r_cnt;

endmodule

// File: rtl/hazard_control_unit.sv
// rtl/hazard_control_unit.sv - stall/flush/enable and forwarding control for the IF/ID and ID/EX registers
module hazard_control_unit
  import hazard_pkg::*;
#(
  parameter int REG_AW         = 5,
  parameter int MULDIV_LATENCY = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [REG_AW-1:0] rs_d,
  input  logic [REG_AW-1:0] rt_d,
  input  logic [REG_AW-1:0] rs_e,
  input  logic [REG_AW-1:0] rt_e,
  input  logic [REG_AW-1:0] write_reg_e,
  input  logic [REG_AW-1:0] write_reg_m,
  input  logic [REG_AW-1:0] write_reg_w,
  input  logic              reg_write_e,
  input  logic              reg_write_m,
  input  logic              reg_write_w,
  input  logic              mem_to_reg_e,
  input  logic              mem_to_reg_m,
  input  logic              branch_d,
  input  logic              pc_src_d,
  input  logic              muldiv_start_e,
  output logic              stall_f,
  output logic              stall_d,
  output logic              flush_d,
  output logic              haz_clr,
  output logic              haz_enable,
  output logic              forward_a_d,
  output logic              forward_b_d,
  output logic [1:0]        forward_a_e,
  output logic [1:0]        forward_b_e,
  output logic              muldiv_busy
);

  localparam int CW = (MULDIV_LATENCY > 2) ? $clog2(MULDIV_LATENCY) : 1;

  hz_state_e     r_state;
  logic          w_run;
  logic          w_last;
  logic [CW-1:0] w_cnt;
  logic          w_lw_stall;
  logic          w_br_stall;
  logic          w_hz;
  logic          w_e_hits_d;
  logic          w_m_hits_d;

  // Register 0 is hardwired, so no compare may ever match on address 0.
  function automatic logic reg_match(input logic [REG_AW-1:0] a, input logic [REG_AW-1:0] b);
    return (a != '0) && (a == b);
  endfunction

  function automatic logic [1:0] fwd_sel(input logic [REG_AW-1:0] src,
                                         input logic [REG_AW-1:0] wr_m, input logic we_m,
                                         input logic [REG_AW-1:0] wr_w, input logic we_w);
    if (we_m && reg_match(src, wr_m))      return FWD_MEM;
    else if (we_w && reg_match(src, wr_w)) return FWD_WB;
    else                                   return FWD_RF;
  endfunction

  assign w_run      = (r_state == RUN);
  assign w_e_hits_d = reg_match(rs_d, write_reg_e) || reg_match(rt_d, write_reg_e);
  assign w_m_hits_d = reg_match(rs_d, write_reg_m) || reg_match(rt_d, write_reg_m);
  assign w_lw_stall = mem_to_reg_e && reg_write_e && w_e_hits_d;
  assign w_br_stall = branch_d && ((reg_write_e && w_e_hits_d) || (mem_to_reg_m && w_m_hits_d));
  assign w_hz       = w_lw_stall || w_br_stall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= RUN;
    end else begin
      case (r_state)
        RUN:     if (muldiv_start_e) r_state <= MD_BUSY;
        MD_BUSY: if (w_last)         r_state <= RUN;
        default:                     r_state <= RUN;
      endcase
    end
  end

  muldiv_busy_ctr #(
    .LATENCY (MULDIV_LATENCY),
    .CW      (CW)
  ) u_busy_ctr (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_load (w_run && muldiv_start_e),
    .i_dec  (!w_run),
    .o_last (w_last),
    .o_cnt  (w_cnt)
  );

  // Gating with rst_n forces the reset-time values regardless of datapath inputs.
  assign stall_f     = rst_n && (!w_run || w_hz);
  assign stall_d     = rst_n && (!w_run || w_hz);
  assign flush_d     = rst_n && w_run && pc_src_d && !w_hz;
  assign haz_clr     = !rst_n || (w_run && w_hz);
  assign haz_enable  = !rst_n || w_run;
  assign muldiv_busy = !w_run;

  assign forward_a_d = rst_n && reg_write_m && reg_match(rs_d, write_reg_m);
  assign forward_b_d = rst_n && reg_write_m && reg_match(rt_d, write_reg_m);
  assign forward_a_e = rst_n ? fwd_sel(rs_e, write_reg_m, reg_write_m, write_reg_w, reg_write_w) : FWD_RF;
  assign forward_b_e = rst_n ? fwd_sel(rt_e, write_reg_m, reg_write_m, write_reg_w, reg_write_w) : FWD_RF;

endmodule

// File: tb/tb_hazard_control_unit.sv
// tb/tb_hazard_control_unit.sv - directed and randomized checks against a behavioural hazard model
module tb_hazard_control_unit;

  localparam int AW  = 5;
  localparam int LAT = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [AW-1:0] rs_d, rt_d, rs_e, rt_e, write_reg_e, write_reg_m, write_reg_w;
  logic          reg_write_e, reg_write_m, reg_write_w, mem_to_reg_e, mem_to_reg_m;
  logic          branch_d, pc_src_d, muldiv_start_e;
  logic          stall_f, stall_d, flush_d, haz_clr, haz_enable;
  logic          forward_a_d, forward_b_d, muldiv_busy;
  logic [1:0]    forward_a_e, forward_b_e;

  int checks   = 0;
  int failures = 0;
  int busy_left = 0;
  int busy_seen;

  always #5 clk = ~clk;

  hazard_control_unit #(.REG_AW(AW), .MULDIV_LATENCY(LAT)) dut (
    .clk(clk), .rst_n(rst_n),
    .rs_d(rs_d), .rt_d(rt_d), .rs_e(rs_e), .rt_e(rt_e),
    .write_reg_e(write_reg_e), .write_reg_m(write_reg_m), .write_reg_w(write_reg_w),
    .reg_write_e(reg_write_e), .reg_write_m(reg_write_m), .reg_write_w(reg_write_w),
    .mem_to_reg_e(mem_to_reg_e), .mem_to_reg_m(mem_to_reg_m),
    .branch_d(branch_d), .pc_src_d(pc_src_d), .muldiv_start_e(muldiv_start_e),
    .stall_f(stall_f), .stall_d(stall_d), .flush_d(flush_d),
    .haz_clr(haz_clr), .haz_enable(haz_enable),
    .forward_a_d(forward_a_d), .forward_b_d(forward_b_d),
    .forward_a_e(forward_a_e), .forward_b_e(forward_b_e),
    .muldiv_busy(muldiv_busy)
  );

  task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d t=%0t", tag, obs, exp, $time);
    end
  endtask

  function automatic bit hit(input logic [AW-1:0] a, input logic [AW-1:0] b);
    return (a != 0) && (a == b);
  endfunction

  function automatic logic [1:0] ref_fwd_e(input logic [AW-1:0] src);
    if (!rst_n) return 2'd0;
    if (reg_write_m && hit(src, write_reg_m)) return 2'd2;
    if (reg_write_w && hit(src, write_reg_w)) return 2'd1;
    return 2'd0;
  endfunction

  task automatic check_all();
    bit busy, lw, br, hz;
    busy = rst_n && (busy_left > 0);
    lw = mem_to_reg_e && reg_write_e && (hit(rs_d, write_reg_e) || hit(rt_d, write_reg_e));
    br = branch_d && ((reg_write_e && (hit(rs_d, write_reg_e) || hit(rt_d, write_reg_e))) ||
                      (mem_to_reg_m && (hit(rs_d, write_reg_m) || hit(rt_d, write_reg_m))));
    hz = lw || br;
    chk("stall_f",     {1'b0, stall_f},     {1'b0, rst_n && (busy || hz)});
    chk("stall_d",     {1'b0, stall_d},     {1'b0, rst_n && (busy || hz)});
    chk("flush_d",     {1'b0, flush_d},     {1'b0, rst_n && !busy && pc_src_d && !hz});
    chk("haz_clr",     {1'b0, haz_clr},     {1'b0, !rst_n || (!busy && hz)});
    chk("haz_enable",  {1'b0, haz_enable},  {1'b0, !rst_n || !busy});
    chk("muldiv_busy", {1'b0, muldiv_busy}, {1'b0, busy});
    chk("forward_a_d", {1'b0, forward_a_d}, {1'b0, rst_n && reg_write_m && hit(rs_d, write_reg_m)});
    chk("forward_b_d", {1'b0, forward_b_d}, {1'b0, rst_n && reg_write_m && hit(rt_d, write_reg_m)});
    chk("forward_a_e", forward_a_e, ref_fwd_e(rs_e));
    chk("forward_b_e", forward_b_e, ref_fwd_e(rt_e));
  endtask

  // Behavioural occupancy model: remaining frozen cycles after a start.
  task automatic cycle();
    #2;
    if (!rst_n) busy_left = 0;
    check_all();
    @(posedge clk);
    if (!rst_n)             busy_left = 0;
    else if (busy_left > 0) busy_left--;
    else if (muldiv_start_e) busy_left = LAT - 1;
    #1;
  endtask

  task automatic idle();
    {rs_d, rt_d, rs_e, rt_e, write_reg_e, write_reg_m, write_reg_w} = '0;
    {reg_write_e, reg_write_m, reg_write_w, mem_to_reg_e, mem_to_reg_m} = '0;
    {branch_d, pc_src_d, muldiv_start_e} = '0;
  endtask

  task automatic randomize_inputs();
    rs_d = AW'($urandom_range(0, 7)); rt_d = AW'($urandom_range(0, 7));
    rs_e = AW'($urandom_range(0, 7)); rt_e = AW'($urandom_range(0, 7));
    write_reg_e = AW'($urandom_range(0, 7));
    write_reg_m = AW'($urandom_range(0, 7));
    write_reg_w = AW'($urandom_range(0, 7));
    {reg_write_e, reg_write_m, reg_write_w, mem_to_reg_e, mem_to_reg_m} = 5'($urandom);
    branch_d = 1'($urandom); pc_src_d = 1'($urandom);
    muldiv_start_e = ($urandom_range(0, 7) == 0);
  endtask

  initial begin
    rst_n = 1'b0;
    randomize_inputs();
    #2;
    chk("rst_haz_clr", {1'b0, haz_clr}, 2'd1);
    chk("rst_haz_en",  {1'b0, haz_enable}, 2'd1);
    chk("rst_stall",   {1'b0, stall_f}, 2'd0);
    chk("rst_fwd_a_e", forward_a_e, 2'd0);
    cycle();
    cycle();
    rst_n = 1'b1;
    idle();
    cycle();

    // load-use: lw $8 in EX, consumer in ID
    mem_to_reg_e = 1'b1; reg_write_e = 1'b1; write_reg_e = 8; rs_d = 8;
    #2; chk("lu_stall", {1'b0, stall_f}, 2'd1); chk("lu_clr", {1'b0, haz_clr}, 2'd1);
    cycle();
    idle(); rs_e = 8; write_reg_m = 8; reg_write_m = 1'b1; mem_to_reg_m = 1'b1;
    #2; chk("lu_fwd_mem", forward_a_e, 2'b10);
    cycle();
    idle(); rs_e = 8; write_reg_w = 8; reg_write_w = 1'b1;
    #2; chk("lu_fwd_wb", forward_a_e, 2'b01);
    cycle();

    // forwarding priority and register 0
    idle(); rs_e = 5; write_reg_m = 5; write_reg_w = 5; reg_write_m = 1'b1; reg_write_w = 1'b1;
    #2; chk("prio_mem", forward_a_e, 2'b10);
    cycle();
    rs_e = 0; write_reg_m = 0; write_reg_w = 0;
    #2; chk("r0_nofwd", forward_a_e, 2'b00);
    cycle();

    // branch compare hazard, then ID forward, then taken flush
    idle(); branch_d = 1'b1; rs_d = 3; write_reg_e = 3; reg_write_e = 1'b1;
    #2; chk("br_stall", {1'b0, stall_d}, 2'd1);
    cycle();
    idle(); branch_d = 1'b1; rs_d = 3; write_reg_m = 3; reg_write_m = 1'b1; pc_src_d = 1'b1;
    #2; chk("br_fwd_d", {1'b0, forward_a_d}, 2'd1); chk("br_flush", {1'b0, flush_d}, 2'd1);
    cycle();

    // mul/div freeze for LAT-1 cycles, second start ignored
    idle(); muldiv_start_e = 1'b1;
    cycle();
    busy_seen = 0;
    for (int i = 0; i < 8; i++) begin
      muldiv_start_e = (i == 1);
      #2;
      if (muldiv_busy && !haz_enable) busy_seen++;
      cycle();
    end
    chk("md_busy_len", 2'(busy_seen), 2'(LAT - 1));

    // reset while busy with cnt=2
    idle(); muldiv_start_e = 1'b1;
    cycle();
    muldiv_start_e = 1'b0;
    cycle();
    rst_n = 1'b0;
    #2; chk("mid_rst_en", {1'b0, haz_enable}, 2'd1); chk("mid_rst_busy", {1'b0, muldiv_busy}, 2'd0);
    cycle();
    rst_n = 1'b1;
    cycle();

    for (int i = 0; i < 400; i++) begin
      randomize_inputs();
      rst_n = ($urandom_range(0, 49) != 0);
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
